intt_iterative_scaled: RTL and testbench

//  Iterative, memory-based inverse NTT over Z_q. Consumes one spectrum frame in bit-reversed order
//  (the layout the pipelined forward NTT emits) and returns the time-domain frame in natural order,

---
 rtl/ntt_pkg.sv | 66 ++++++
 rtl/ntt_mod_mul.sv | 18 +
 rtl/intt_iterative_scaled.sv | 168 ++++++++++++++++
 tb/tb_intt_iterative_scaled.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared types, configuration constants and modular-arithmetic helpers for the
// iterative inverse NTT.
// Contents: transform configuration (W, N, Q, OMEGA_INV, N_INV), FSM state enum,
// frame/index typedefs, bit_reverse(), gen_twiddles(), mod_add(), mod_sub().
package ntt_pkg;

    localparam int unsigned W      = 32;
    localparam int unsigned W2     = 2 * W;
    localparam int unsigned N      = 8;
    localparam int unsigned LOG2_N = $clog2(N);

    localparam logic [W-1:0] MODULUS_Q = W'(241);
    localparam logic [W-1:0] OMEGA_INV = W'(233);
    localparam logic [W-1:0] N_INV     = W'(211);

    typedef enum logic [1:0] {IDLE, COMPUTE, SCALE, DONE} state_t;

    typedef logic [N-1:0][W-1:0]   frame_t;
    typedef logic [N/2-1:0][W-1:0] twiddle_rom_t;
    typedef logic [LOG2_N-1:0]     idx_t;
    typedef logic [LOG2_N-2:0]     bfly_t;

    // Reverse the LOG2_N-bit index.
    function automatic idx_t bit_reverse(input idx_t i);
        idx_t r;
        r = '0;
        for (int unsigned b = 0; b < LOG2_N; b++) begin
            r[b] = i[LOG2_N-1-b];
        end
        return r;
    endfunction

    // OMEGA_INV^i mod Q for i = 0..N/2-1, evaluated at elaboration.
    function automatic twiddle_rom_t gen_twiddles();
        twiddle_rom_t rom;
        logic [W2-1:0] acc;
        rom = '0;
        acc = W2'(1);
        for (int unsigned i = 0; i < N/2; i++) begin
            rom[i] = W'(acc);
            acc = (acc * W2'(OMEGA_INV)) % W2'(MODULUS_Q);
        end
        return rom;
    endfunction

    // (a + b) mod Q for a, b in [0, Q-1].
    function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, MODULUS_Q}) begin
            s = s - {1'b0, MODULUS_Q};
        end
        return s[W-1:0];
    endfunction

    // (a - b + Q) mod Q for a, b in [0, Q-1].
    function automatic logic [W-1:0] mod_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] d;
        d = {1'b0, a} + {1'b0, MODULUS_Q} - {1'b0, b};
        if (d >= {1'b0, MODULUS_Q}) begin
            d = d - {1'b0, MODULUS_Q};
        end
        return d[W-1:0];
    endfunction

endpackage

// File: rtl/ntt_mod_mul.sv
// Combinational modular multiplier: p_c = (a * b) mod Q, product formed at 2W bits.
// Ports: a, b (operands in [0, Q-1]); p_c (combinational result).
module ntt_mod_mul
    import ntt_pkg::*;
(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] p_c
);

    logic [W2-1:0] prod;

    always_comb begin
        prod = W2'(a) * W2'(b);
        p_c  = W'(prod % W2'(MODULUS_Q));
    end

endmodule

// File: rtl/intt_iterative_scaled.sv
// Iterative in-place inverse NTT over Z_q. Takes a bit-reversed spectrum frame and
// returns the natural-order time-domain frame, one Cooley-Tukey butterfly per cycle.
// Build option: define INTT_SCALE_EN to multiply the result by N^-1 (SCALE state);
// without it the block outputs N*x[n] mod Q and skips scaling.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   in_valid / in_ready input frame handshake (in_ready high only in IDLE)
//   Data_in             spectrum, Data_in[j] = X[bitrev(j)]
//   out_valid/out_ready result handshake
//   Data_out            working memory, valid when out_valid is high
//   busy                high while COMPUTE or SCALE
module intt_iterative_scaled
    import ntt_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N-1:0][W-1:0]   Data_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N-1:0][W-1:0]   Data_out,
    output logic                  busy
);

    localparam twiddle_rom_t TW_ROM = gen_twiddles();

    state_t state, next_state;
    logic   in_ready_d, out_valid_d, busy_d;

    frame_t mem;
    idx_t   stage;
    bfly_t  bfly;
`ifdef INTT_SCALE_EN
    idx_t   scale_idx;
`endif

    idx_t        half, b_off, top, bot, tw_idx_full;
    bfly_t       tw_idx;
    logic        last_bfly;
    logic [W-1:0] mul_a, mul_b, mul_p;

    // Butterfly addressing: top = 2*half*g + b, bot = top + half, twiddle b*N/(2*half).
    always_comb begin
        half        = idx_t'(1) << stage;
        b_off       = idx_t'(bfly) & (half - idx_t'(1));
        top         = ((idx_t'(bfly) - b_off) << 1) | b_off;
        bot         = top | half;
        tw_idx_full = b_off << (idx_t'(LOG2_N - 1) - stage);
        tw_idx      = bfly_t'(tw_idx_full);
        last_bfly   = (stage == idx_t'(LOG2_N - 1)) && (bfly == bfly_t'(N/2 - 1));
    end

    // Single multiplier shared by the butterfly and the N^-1 scaling pass.
`ifdef INTT_SCALE_EN
    assign mul_a = (state == SCALE) ? mem[scale_idx] : mem[bot];
    assign mul_b = (state == SCALE) ? N_INV : TW_ROM[tw_idx];
`else
    assign mul_a = mem[bot];
    assign mul_b = TW_ROM[tw_idx];
`endif

    ntt_mod_mul u_mul (
        .a   (mul_a),
        .b   (mul_b),
        .p_c (mul_p)
    );

    // State register and registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= next_state;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            busy      <= busy_d;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) next_state = COMPUTE;
            end
            COMPUTE: begin
                if (last_bfly) begin
`ifdef INTT_SCALE_EN
                    next_state = SCALE;
`else
                    next_state = DONE;
`endif
                end
            end
`ifdef INTT_SCALE_EN
            SCALE: begin
                if (scale_idx == idx_t'(N - 1)) next_state = DONE;
            end
`endif
            DONE: begin
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Output decode from the upcoming state so the registered outputs track it.
    always_comb begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        case (next_state)
            IDLE:    in_ready_d  = 1'b1;
            COMPUTE: busy_d      = 1'b1;
            SCALE:   busy_d      = 1'b1;
            DONE:    out_valid_d = 1'b1;
            default: ;
        endcase
    end

    // Working memory and counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem   <= '0;
            stage <= '0;
            bfly  <= '0;
`ifdef INTT_SCALE_EN
            scale_idx <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        mem   <= Data_in;
                        stage <= '0;
                        bfly  <= '0;
`ifdef INTT_SCALE_EN
                        scale_idx <= '0;
`endif
                    end
                end
                COMPUTE: begin
                    mem[top] <= mod_add(mem[top], mul_p);
                    mem[bot] <= mod_sub(mem[top], mul_p);
                    bfly     <= bfly + bfly_t'(1);
                    if (bfly == bfly_t'(N/2 - 1)) begin
                        stage <= last_bfly ? '0 : stage + idx_t'(1);
                    end
                end
`ifdef INTT_SCALE_EN
                SCALE: begin
                    mem[scale_idx] <= mul_p;
                    scale_idx      <= scale_idx + idx_t'(1);
                end
`endif
                default: ;
            endcase
        end
    end

    assign Data_out = mem;

endmodule

// File: tb/tb_intt_iterative_scaled.sv
`timescale 1ns/1ps
module tb_intt_iterative_scaled;
    import ntt_pkg::*;

    localparam longint QL    = 241;
    localparam longint OMEGA = 30;
    localparam longint OINV  = 233;
    localparam longint NINV  = 211;
`ifdef INTT_SCALE_EN
    localparam int  LAT    = int'(LOG2_N * N / 2 + N);
    localparam bit  SCALED = 1'b1;
`else
    localparam int  LAT    = int'(LOG2_N * N / 2);
    localparam bit  SCALED = 1'b0;
`endif

    logic   clk, reset, in_valid, in_ready, out_valid, out_ready, busy;
    frame_t Data_in, Data_out;

    intt_iterative_scaled dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Data_in   (Data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Data_out  (Data_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    frame_t exp_frame;
    bit     exp_valid = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_frame(input string name, input frame_t act, input frame_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model: direct DFT sums ----------------
    function automatic int unsigned brev(input int unsigned j);
        int unsigned r = 0;
        for (int b = 0; b < int'(LOG2_N); b++) r = (r << 1) | ((j >> b) & 1);
        return r;
    endfunction

    function automatic longint powmod(input longint base, input longint e);
        longint r = 1;
        for (longint i = 0; i < e; i++) r = (r * base) % QL;
        return r;
    endfunction

    // Data_in (bit-reversed spectrum) -> expected natural-order output.
    function automatic frame_t model_intt(input frame_t din);
        longint xs [N];
        longint acc;
        frame_t r;
        for (int j = 0; j < int'(N); j++) xs[brev(j)] = longint'(din[j]);
        for (int n = 0; n < int'(N); n++) begin
            acc = 0;
            for (int k = 0; k < int'(N); k++) acc = (acc + xs[k] * powmod(OINV, n * k)) % QL;
            if (SCALED) acc = (acc * NINV) % QL;
            r[n] = W'(acc);
        end
        return r;
    endfunction

    // Natural-order time samples -> forward NTT in bit-reversed layout.
    function automatic frame_t fwd_ntt(input frame_t x);
        longint acc;
        frame_t r;
        for (int k = 0; k < int'(N); k++) begin
            acc = 0;
            for (int n = 0; n < int'(N); n++) acc = (acc + longint'(x[n]) * powmod(OMEGA, n * k)) % QL;
            r[brev(k)] = W'(acc);
        end
        return r;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            chk("out_valid_qualified", exp_valid, 1);
            if (exp_valid) begin
                chk_frame("data_out", Data_out, exp_frame);
                chk("in_ready_in_done", in_ready, 0);
                chk("busy_in_done", busy, 0);
            end
        end
    end

    function automatic frame_t rand_frame();
        frame_t f;
        for (int j = 0; j < int'(N); j++) f[j] = W'($urandom_range(0, 240));
        return f;
    endfunction

    // Send one frame, measure latency, hold off out_ready for 'hold' cycles, consume.
    task automatic run_frame(input frame_t din, input int hold, input bit pulse);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("in_ready_before_send", in_ready, 1);
        exp_frame = model_intt(din);
        Data_in   = din;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        Data_in   = rand_frame();
        exp_valid = 1'b1;
        chk("busy_after_accept", busy, 1);
        chk("in_ready_after_accept", in_ready, 0);
        n = 0;
        while (!out_valid && n < 300) begin
            in_valid = (pulse && n == 3);
            if (in_valid) Data_in = rand_frame();
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        chk("latency", n, LAT);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("out_valid_held", out_valid, 1);
            chk("in_ready_held_low", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_valid = 1'b0;
        chk("out_valid_after_handshake", out_valid, 0);
        chk("in_ready_after_handshake", in_ready, 1);
    endtask

    frame_t ones, d3, d4, x5, d5, lit;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; Data_in = '0;
        #1;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_busy", busy, 0);
        chk_frame("reset_data_out", Data_out, '0);
        @(posedge clk); @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk("in_ready_after_release", in_ready, 1);

        // Test 1/2: all-ones spectrum -> impulse.
        for (int j = 0; j < int'(N); j++) ones[j] = W'(1);
        lit = '0; lit[0] = SCALED ? W'(1) : W'(8);
        chk_frame("model_pin_ones", model_intt(ones), lit);
        run_frame(ones, 0, 1'b0);

        // Test 3: X = [8,0,...] -> constant.
        d3 = '0; d3[0] = W'(8);
        for (int j = 0; j < int'(N); j++) lit[j] = SCALED ? W'(1) : W'(8);
        chk_frame("model_pin_const", model_intt(d3), lit);
        run_frame(d3, 2, 1'b0);

        // Test 4: all Q-1.
        for (int j = 0; j < int'(N); j++) d4[j] = W'(240);
        lit = '0; lit[0] = SCALED ? W'(240) : W'(233);
        chk_frame("model_pin_qm1", model_intt(d4), lit);
        run_frame(d4, 0, 1'b0);

        // Test 5: round trip of x = 1..8.
        for (int j = 0; j < int'(N); j++) begin
            x5[j]  = W'(j + 1);
            lit[j] = SCALED ? W'(j + 1) : W'(8 * (j + 1));
        end
        d5 = fwd_ntt(x5);
        chk_frame("model_pin_roundtrip", model_intt(d5), lit);
        run_frame(d5, 1, 1'b0);

        // Test 6: backpressure and an ignored in_valid pulse while computing.
        run_frame(rand_frame(), 5, 1'b1);

        // Test 7: reset during the 6th COMPUTE cycle, then a clean frame.
        Data_in  = rand_frame();
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        exp_valid = 1'b0;
        reset     = 1'b1;
        #1;
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_busy", busy, 0);
        chk("midreset_in_ready", in_ready, 1);
        chk_frame("midreset_data_out", Data_out, '0);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk("in_ready_after_midreset", in_ready, 1);
        run_frame(ones, 0, 1'b0);

        // Randomized frames with random backpressure.
        for (int f = 0; f < 15; f++) begin
            run_frame(rand_frame(), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
